aes128_encrypt: RTL and testbench



---
 rtl/aes128_encrypt.sv | 214 +++++++++++++++++++++
 tb/tb_aes128_encrypt.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt.sv
`default_nettype none
// ============================================================================
// Module   : aes128_encrypt (with helper aes128_sbox)
// Purpose  : Iterative AES-128 encryption core. It computes one FIPS-197 round
//            per clock, with on-the-fly round-key expansion. Latency is 10
//            cycles from the accepting edge to the done pulse.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            start      - encrypt request, sampled only while busy=0
//            plaintext  - 128-bit input block, bits [127:120] = byte in0
//            key        - 128-bit cipher key, bits [127:120] = key byte 0
//            ciphertext - 128-bit result, same byte ordering as plaintext
//            busy       - high while rounds are in progress
//            done       - one-cycle pulse when ciphertext becomes valid
// Options  : AES_OUT_MASK_EN - when defined, ciphertext reads 0 while busy=1
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes128_sbox : combinational AES forward S-box (256-entry lookup)
//   in_i  - byte to substitute
//   out_o - substituted byte
// ----------------------------------------------------------------------------
module aes128_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Entry 0 sits in the most significant byte. The bit offset of entry k is
  // therefore 8*(255-k), and 255-k equals ~k for an 8-bit value.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = c_SBOX[{~in_i, 3'b000} +: 8];
endmodule

// ----------------------------------------------------------------------------
// aes128_encrypt : top-level iterative AES-128 engine
// ----------------------------------------------------------------------------
module aes128_encrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;      // cipher state
  logic [127:0] rk_q,  rk_d;       // current round key
  logic [127:0] ct_q,  ct_d;       // last completed result
  logic [3:0]   round_q, round_d;  // round being computed next (1..10)
  logic         done_q, done_d;

  logic [127:0] w_sub, w_sr, w_mix, w_rk_next;
  logic [31:0]  w_rot, w_subw, w_temp;
  logic [31:0]  w_kw0, w_kw1, w_kw2, w_kw3;
  logic [7:0]   w_rcon;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    mix_col[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    mix_col[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    mix_col[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    mix_col[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  endfunction

  // SubBytes on all 16 state bytes
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes128_sbox u_sbox (
      .in_i  (blk_q[127-8*i -: 8]),
      .out_o (w_sub[127-8*i -: 8])
    );
  end

  // ShiftRows: byte i is (row i%4, col i/4). Row r rotates left by r columns,
  // so out[r][c] takes in[r][(c+r)%4].
  for (genvar i = 0; i < 16; i++) begin : g_sr
    localparam int SRC = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
    assign w_sr[127-8*i -: 8] = w_sub[127-8*SRC -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign w_mix[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
  end

  // Key schedule: temp = SubWord(RotWord(w3)) ^ Rcon, then cascade the XORs
  assign w_rot = {rk_q[23:0], rk_q[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksub
    aes128_sbox u_sbox (
      .in_i  (w_rot[31-8*j -: 8]),
      .out_o (w_subw[31-8*j -: 8])
    );
  end

  always_comb begin
    w_rcon = 8'h00;
    case (round_q)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_temp    = w_subw ^ {w_rcon, 24'h000000};
  assign w_kw0     = rk_q[127:96] ^ w_temp;
  assign w_kw1     = rk_q[95:64]  ^ w_kw0;
  assign w_kw2     = rk_q[63:32]  ^ w_kw1;
  assign w_kw3     = rk_q[31:0]   ^ w_kw2;
  assign w_rk_next = {w_kw0, w_kw1, w_kw2, w_kw3};

  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          blk_d   = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_d = w_rk_next;
        if (round_q == 4'd10) begin
          // The final round skips MixColumns.
          ct_d    = w_sr ^ w_rk_next;
          done_d  = 1'b1;
          round_d = 4'd0;
          fsm_d   = ST_IDLE;
        end else begin
          blk_d   = w_mix ^ w_rk_next;
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      blk_q   <= 128'h0;
      rk_q    <= 128'h0;
      ct_q    <= 128'h0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign busy = (fsm_q == ST_RUN);
  assign done = done_q;

`ifdef AES_OUT_MASK_EN
  // Hide the held result while a new block is being processed.
  assign ciphertext = busy ? 128'h0 : ct_q;
`else
  assign ciphertext = ct_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_encrypt
// Purpose  : Self-checking bench for aes128_encrypt. A reference AES-128
//            (S-box derived from GF(2^8) inversion, full key expansion) and a
//            transaction-level timing model are compared against the DUT on
//            every falling edge. Directed FIPS-197 vectors are used as stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  aes128_encrypt dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference AES ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] inv, t, s;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);  // x^254 = x^-1, 0 -> 0
    s = inv;
    t = inv;
    for (int k = 0; k < 4; k++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] w [176];
    logic [7:0] t [4];
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] v [16];
    logic [7:0] m [16];
    logic [7:0] rc, tmp;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp];
        rc   = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          v[4*c+r] = u[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            m[4*c+r] = gmul(8'h02, v[4*c+r]) ^ gmul(8'h03, v[4*c+(r+1)%4])
                     ^ v[4*c+(r+2)%4] ^ v[4*c+(r+3)%4];
          else
            m[4*c+r] = v[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = m[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- transaction timing model ----------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_ct   = '0;
  logic [127:0] m_pend = '0;
  int           m_cnt  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ct   = '0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_pend = aes_ref(plaintext, key);
        end
      end else begin
        m_cnt++;
        if (m_cnt == 10) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_ct   = m_pend;
        end
      end
    end
  end

  logic [127:0] exp_ct;
  always @(negedge clk) begin
`ifdef AES_OUT_MASK_EN
    exp_ct = m_busy ? 128'h0 : m_ct;
`else
    exp_ct = m_ct;
`endif
    check("cyc_busy", {127'h0, busy}, {127'h0, m_busy});
    check("cyc_done", {127'h0, done}, {127'h0, m_done});
    check("cyc_ct", ciphertext, exp_ct);
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string name, input logic [127:0] pt, input logic [127:0] k,
                        input logic [127:0] exp);
    int lat;
    @(negedge clk);
    start = 1'b1;
    plaintext = pt;
    key = k;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 30);
    // The first falling edge after the accepting rising edge is lat=1.
    check({name, "_latency"}, 128'(lat - 1), 128'd10);
    check({name, "_ct"}, ciphertext, exp);
  endtask

  int done_at [$];
  int ndone;

  initial begin
    for (int x = 0; x < 256; x++) sb[x] = sbox_math(8'(x));

    // Pin the reference model to published vectors.
    check("ref_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
    check("ref_appb", aes_ref(B_PT, B_KEY), B_CT);
    check("ref_zero", aes_ref(128'h0, 128'h0), Z_CT);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    check("rst_ct", ciphertext, 128'h0);
    rst = 1'b0;

    run_op("c1", C1_PT, C1_KEY, C1_CT);
    run_op("appb", B_PT, B_KEY, B_CT);
    run_op("zero", 128'h0, 128'h0, Z_CT);

    // start held high: back-to-back operations every 11 cycles
    @(negedge clk);
    start = 1'b1;
    plaintext = '0;
    key = '0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(i);
        check("held_ct", ciphertext, Z_CT);
      end
      if (i == 44) start = 1'b0;
    end
    check("held_ndone", 128'(done_at.size()), 128'd4);
    for (int i = 0; i < done_at.size(); i++)
      check("held_pos", 128'(done_at[i]), 128'(11 * (i + 1)));
    repeat (3) @(negedge clk);

    // start pulsed mid-operation with different inputs is ignored
    @(negedge clk);
    start = 1'b1;
    plaintext = C1_PT;
    key = C1_KEY;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin
        start = 1'b1;
        plaintext = B_PT;
        key = B_KEY;
      end
      if (i == 4) start = 1'b0;
      if (done) begin
        ndone++;
        check("ign_pos", 128'(i), 128'd11);
        check("ign_ct", ciphertext, C1_CT);
      end
    end
    check("ign_ndone", 128'(ndone), 128'd1);

    // asynchronous reset during round 5
    @(negedge clk);
    start = 1'b1;
    plaintext = C1_PT;
    key = C1_KEY;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {127'h0, busy}, 128'h0);
    check("arst_done", {127'h0, done}, 128'h0);
    check("arst_ct", ciphertext, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", C1_PT, C1_KEY, C1_CT);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
